id_ex_stage: RTL and testbench

- ID/EX pipeline stage of the pipelined MIPS core, directly downstream of the decode-stage control unit.
- Registers the decoded control bundle plus register-file read data, sign-extended immediate and register specifiers into the Execute stage.
- Detects load-use hazards and stalls Fetch/Decode.
- Inserts bubbles on load-use stalls or branch/jump flush, and counts both events for performance monitoring.

---
 rtl/id_ex_stage_pkg.sv | 20 ++
 rtl/id_ex_stage_hazard_detect.sv | 26 ++
 rtl/id_ex_stage.sv | 160 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared widths and the zero control bundle for the ID/EX stage and its hazard logic.
package id_ex_stage_pkg;

  localparam int ID_EX_AWL = 6;
  localparam int REG_W     = ID_EX_AWL - 1;
  localparam int ALUSEL_W  = ID_EX_AWL - 2;

  typedef struct packed {
    logic mtorfsel;
    logic dmwe;
    logic branch;
    logic aluinsel;
    logic rfdsel;
    logic rfwe;
    logic jump;
  } ctrl_t;

  localparam ctrl_t CTRL_ZERO = ctrl_t'(7'b0000000);

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: an Execute-stage load whose destination feeds a Decode-stage source.
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int RW = REG_W
) (
  input  logic          valid_e_i,
  input  logic          mtorfsel_e_i,
  input  logic          rfwe_e_i,
  input  logic [RW-1:0] rt_e_i,
  input  logic [RW-1:0] rs_d_i,
  input  logic [RW-1:0] rt_d_i,
  output logic          lw_stall_o
);

  logic dep_s;
  logic load_s;

  // $0 is hardwired to zero, so a load targeting it can never create a dependency
  always_comb begin
    dep_s      = (rt_e_i == rs_d_i) | (rt_e_i == rt_d_i);
    load_s     = valid_e_i & mtorfsel_e_i & rfwe_e_i & (rt_e_i != {RW{1'b0}});
    lw_stall_o = load_s & dep_s;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble insertion and saturating stall/flush counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int AWL = ID_EX_AWL,
  parameter int DWL = 32,
  parameter int CWL = 16
) (
  input  logic           CLK,
  input  logic           RSTn,
  input  logic           MtoRFSelD,
  input  logic           DMWED,
  input  logic           BranchD,
  input  logic           ALUInSelD,
  input  logic           RFDSelD,
  input  logic           RFWED,
  input  logic           JumpD,
  input  logic [AWL-3:0] ALUSelD,
  input  logic [DWL-1:0] RD1D,
  input  logic [DWL-1:0] RD2D,
  input  logic [DWL-1:0] SImmD,
  input  logic [AWL-2:0] RsD,
  input  logic [AWL-2:0] RtD,
  input  logic [AWL-2:0] RdD,
  input  logic           FlushE,
  input  logic           ClrCnt,
  output logic           MtoRFSelE,
  output logic           DMWEE,
  output logic           BranchE,
  output logic           ALUInSelE,
  output logic           RFDSelE,
  output logic           RFWEE,
  output logic           JumpE,
  output logic [AWL-3:0] ALUSelE,
  output logic [DWL-1:0] RD1E,
  output logic [DWL-1:0] RD2E,
  output logic [DWL-1:0] SImmE,
  output logic [AWL-2:0] RsE,
  output logic [AWL-2:0] RtE,
  output logic [AWL-2:0] RdE,
  output logic           ValidE,
  output logic           StallF,
  output logic           StallD,
  output logic [CWL-1:0] StallCnt,
  output logic [CWL-1:0] FlushCnt
);

  localparam logic [CWL-1:0] CNT_MAX = {CWL{1'b1}};
  localparam logic [CWL-1:0] CNT_ONE = {{(CWL-1){1'b0}}, 1'b1};

  ctrl_t          ctrl_q, ctrl_d, ctrl_in_s;
  logic [AWL-3:0] alusel_q, alusel_d;
  logic [DWL-1:0] rd1_q, rd1_d, rd2_q, rd2_d, simm_q, simm_d;
  logic [AWL-2:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic           valid_q, valid_d;
  logic [CWL-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic           lw_stall_s, bubble_s;

  hazard_detect #(.RW(AWL-1)) u_hazard (
    .valid_e_i    (valid_q),
    .mtorfsel_e_i (ctrl_q.mtorfsel),
    .rfwe_e_i     (ctrl_q.rfwe),
    .rt_e_i       (rt_q),
    .rs_d_i       (RsD),
    .rt_d_i       (RtD),
    .lw_stall_o   (lw_stall_s)
  );

  assign ctrl_in_s = '{mtorfsel: MtoRFSelD, dmwe: DMWED, branch: BranchD, aluinsel: ALUInSelD,
                       rfdsel: RFDSelD, rfwe: RFWED, jump: JumpD};
  assign bubble_s  = FlushE | lw_stall_s;

  // Next-state: bubble zeroes the whole slot; flush takes priority over stall in the counters
  always_comb begin
    ctrl_d      = ctrl_in_s;
    alusel_d    = ALUSelD;
    rd1_d       = RD1D;
    rd2_d       = RD2D;
    simm_d      = SImmD;
    rs_d        = RsD;
    rt_d        = RtD;
    rd_d        = RdD;
    valid_d     = 1'b1;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bubble_s) begin
      ctrl_d   = CTRL_ZERO;
      alusel_d = {(AWL-2){1'b0}};
      rd1_d    = {DWL{1'b0}};
      rd2_d    = {DWL{1'b0}};
      simm_d   = {DWL{1'b0}};
      rs_d     = {(AWL-1){1'b0}};
      rt_d     = {(AWL-1){1'b0}};
      rd_d     = {(AWL-1){1'b0}};
      valid_d  = 1'b0;
    end else begin
      valid_d  = 1'b1;
    end
    if (ClrCnt) begin
      stall_cnt_d = {CWL{1'b0}};
      flush_cnt_d = {CWL{1'b0}};
    end else if (FlushE) begin
      flush_cnt_d = (flush_cnt_q != CNT_MAX) ? flush_cnt_q + CNT_ONE : flush_cnt_q;
    end else if (lw_stall_s) begin
      stall_cnt_d = (stall_cnt_q != CNT_MAX) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Pipeline slot and counter registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ctrl_q      <= CTRL_ZERO;
      alusel_q    <= {(AWL-2){1'b0}};
      rd1_q       <= {DWL{1'b0}};
      rd2_q       <= {DWL{1'b0}};
      simm_q      <= {DWL{1'b0}};
      rs_q        <= {(AWL-1){1'b0}};
      rt_q        <= {(AWL-1){1'b0}};
      rd_q        <= {(AWL-1){1'b0}};
      valid_q     <= 1'b0;
      stall_cnt_q <= {CWL{1'b0}};
      flush_cnt_q <= {CWL{1'b0}};
    end else begin
      ctrl_q      <= ctrl_d;
      alusel_q    <= alusel_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      simm_q      <= simm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign MtoRFSelE = ctrl_q.mtorfsel;
  assign DMWEE     = ctrl_q.dmwe;
  assign BranchE   = ctrl_q.branch;
  assign ALUInSelE = ctrl_q.aluinsel;
  assign RFDSelE   = ctrl_q.rfdsel;
  assign RFWEE     = ctrl_q.rfwe;
  assign JumpE     = ctrl_q.jump;
  assign ALUSelE   = alusel_q;
  assign RD1E      = rd1_q;
  assign RD2E      = rd2_q;
  assign SImmE     = simm_q;
  assign RsE       = rs_q;
  assign RtE       = rt_q;
  assign RdE       = rd_q;
  assign ValidE    = valid_q;
  assign StallF    = lw_stall_s;
  assign StallD    = lw_stall_s;
  assign StallCnt  = stall_cnt_q;
  assign FlushCnt  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a spec-level model pushes expected E-slot contents and counters to a queue.
module tb_id_ex_stage;

  localparam int AWL = 6;
  localparam int DWL = 32;
  localparam int CWL = 4;
  localparam int EW  = 7 + (AWL-2) + 3*DWL + 3*(AWL-1);

  logic CLK = 1'b0;
  logic RSTn;
  logic MtoRFSelD, DMWED, BranchD, ALUInSelD, RFDSelD, RFWED, JumpD;
  logic [AWL-3:0] ALUSelD;
  logic [DWL-1:0] RD1D, RD2D, SImmD;
  logic [AWL-2:0] RsD, RtD, RdD;
  logic FlushE, ClrCnt;
  logic MtoRFSelE, DMWEE, BranchE, ALUInSelE, RFDSelE, RFWEE, JumpE;
  logic [AWL-3:0] ALUSelE;
  logic [DWL-1:0] RD1E, RD2E, SImmE;
  logic [AWL-2:0] RsE, RtE, RdE;
  logic ValidE, StallF, StallD;
  logic [CWL-1:0] StallCnt, FlushCnt;

  always #5 CLK = ~CLK;

  id_ex_stage #(.AWL(AWL), .DWL(DWL), .CWL(CWL)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .MtoRFSelD(MtoRFSelD), .DMWED(DMWED), .BranchD(BranchD), .ALUInSelD(ALUInSelD),
    .RFDSelD(RFDSelD), .RFWED(RFWED), .JumpD(JumpD), .ALUSelD(ALUSelD),
    .RD1D(RD1D), .RD2D(RD2D), .SImmD(SImmD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .FlushE(FlushE), .ClrCnt(ClrCnt),
    .MtoRFSelE(MtoRFSelE), .DMWEE(DMWEE), .BranchE(BranchE), .ALUInSelE(ALUInSelE),
    .RFDSelE(RFDSelE), .RFWEE(RFWEE), .JumpE(JumpE), .ALUSelE(ALUSelE),
    .RD1E(RD1E), .RD2E(RD2E), .SImmE(SImmE), .RsE(RsE), .RtE(RtE), .RdE(RdE),
    .ValidE(ValidE), .StallF(StallF), .StallD(StallD),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  typedef struct {
    logic [EW-1:0]  e;
    logic           v;
    logic [CWL-1:0] sc;
    logic [CWL-1:0] fc;
    string          tag;
  } exp_t;

  exp_t sb[$];

  logic           m_valid, m_mtor, m_rfwe;
  logic [AWL-2:0] m_rt;
  logic [CWL-1:0] m_sc, m_fc;
  int n_cmp = 0;
  int n_fail = 0;

  wire [EW-1:0] e_obs = {MtoRFSelE, DMWEE, BranchE, ALUInSelE, RFDSelE, RFWEE, JumpE,
                         ALUSelE, RD1E, RD2E, SImmE, RsE, RtE, RdE};
  wire [EW-1:0] d_vec = {MtoRFSelD, DMWED, BranchD, ALUInSelD, RFDSelD, RFWED, JumpD,
                         ALUSelD, RD1D, RD2D, SImmD, RsD, RtD, RdD};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_d();
    {MtoRFSelD, DMWED, BranchD, ALUInSelD, RFDSelD, RFWED, JumpD} = 7'b0000000;
    ALUSelD = 4'b0000;
    RD1D = 32'h0; RD2D = 32'h0; SImmD = 32'h0;
    RsD = 5'd0; RtD = 5'd0; RdD = 5'd0;
    FlushE = 1'b0; ClrCnt = 1'b0;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_mtor = 1'b0; m_rfwe = 1'b0; m_rt = 5'd0;
    m_sc = 4'd0; m_fc = 4'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".e"}, e_obs, 128'd0);
    check({tag, ".valid"}, ValidE, 128'd0);
    check({tag, ".stall_cnt"}, StallCnt, 128'd0);
    check({tag, ".flush_cnt"}, FlushCnt, 128'd0);
    check({tag, ".stallf"}, StallF, 128'd0);
  endtask

  // Called just after a rising edge with D inputs already driven.
  task automatic step(input string tag);
    exp_t x;
    logic lw;
    lw = m_valid & m_mtor & m_rfwe & (m_rt != 5'd0) & ((m_rt == RsD) | (m_rt == RtD));
    #1;
    check({tag, ".stallf"}, StallF, lw);
    check({tag, ".stalld"}, StallD, lw);
    x.tag = tag;
    if (FlushE | lw) begin
      x.e = '0; x.v = 1'b0;
    end else begin
      x.e = d_vec; x.v = 1'b1;
    end
    if (ClrCnt) begin
      m_sc = 4'd0; m_fc = 4'd0;
    end else if (FlushE) begin
      if (m_fc != 4'hF) m_fc = m_fc + 4'd1;
    end else if (lw) begin
      if (m_sc != 4'hF) m_sc = m_sc + 4'd1;
    end
    x.sc = m_sc; x.fc = m_fc;
    m_valid = x.v;
    m_mtor  = x.e[EW-1];
    m_rfwe  = x.e[EW-6];
    m_rt    = x.v ? RtD : 5'd0;
    sb.push_back(x);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".queue"}, 128'd0, 128'd1);
    end else begin
      x = sb.pop_front();
      check({x.tag, ".e"}, e_obs, x.e);
      check({x.tag, ".valid"}, ValidE, x.v);
      check({x.tag, ".stall_cnt"}, StallCnt, x.sc);
      check({x.tag, ".flush_cnt"}, FlushCnt, x.fc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr_d();
    model_reset();
    RSTn = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RSTn = 1'b1;

    RFWED = 1'b1; ALUSelD = 4'b0010; RD1D = 32'h5; RdD = 5'd9;
    step("add");

    for (int i = 0; i < 3; i++) begin
      clr_d(); MtoRFSelD = 1'b1; RFWED = 1'b1; RtD = 5'd8; RsD = 5'd2; SImmD = 32'h10;
      step("lw");
      clr_d(); RFWED = 1'b1; RsD = 5'd8; RtD = 5'd3; RdD = 5'd10; ALUSelD = 4'b0010;
      RD1D = 32'hCAFE_0000 + i;
      step("use_stall");
      step("use_capture");
    end

    #2 RSTn = 1'b0;
    #1 check_all_zero("reset_mid");
    #1 RSTn = 1'b1;
    model_reset();

    clr_d(); MtoRFSelD = 1'b1; RFWED = 1'b1; RtD = 5'd0; RsD = 5'd0;
    step("lw_r0");
    clr_d(); RFWED = 1'b1; RsD = 5'd0; RdD = 5'd4; RD2D = 32'h1234_5678;
    step("use_r0");

    clr_d(); MtoRFSelD = 1'b1; RFWED = 1'b1; RtD = 5'd8;
    step("lw_f");
    clr_d(); RsD = 5'd8; RFWED = 1'b1; FlushE = 1'b1;
    step("flush_lu");

    for (int i = 0; i < 6; i++) begin
      clr_d();
      {MtoRFSelD, DMWED, BranchD, ALUInSelD, RFDSelD, RFWED, JumpD} = 7'($urandom);
      ALUSelD = 4'($urandom);
      RD1D = $urandom; RD2D = $urandom; SImmD = $urandom;
      RsD = 5'($urandom); RtD = 5'($urandom_range(0, 3)); RdD = 5'($urandom);
      step("rand");
    end

    clr_d(); FlushE = 1'b1;
    for (int i = 0; i < 20; i++) step("flush_sat");
    ClrCnt = 1'b1;
    step("clr_flush");

    clr_d(); MtoRFSelD = 1'b1; RFWED = 1'b1; RtD = 5'd7;
    step("lw_c");
    clr_d(); RtD = 5'd7;
    step("use_rt");
    ClrCnt = 1'b1;
    step("clr_stall");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
